alu_req_scheduler: RTL and testbench

//  Shares the single combinational 64-bit ALU between two requesters (decode/exec port 0, debug/load port 1).

---
 rtl/alu_req_scheduler.sv | 155 +++++++++++++++
 tb/tb_alu_req_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - two-port round-robin scheduler for one shared 64-bit ALU
//
// Purpose: arbitrates between requester 0 (decode/exec) and requester 1 (debug/load),
//   latches the granted request, issues it to the combinational ALU for one cycle,
//   registers the result and returns it on a valid/ready response channel.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready (N=0,1)          request handshake (ready only in IDLE, only for grantee)
//   reqN_cmd/opm/a/b/tag              request payload
//   alu_cmd/opm/a/b                   operands to the shared ALU, held between issues
//   alu_out                           combinational ALU result
//   rsp_valid/ready                   response handshake
//   rsp_data/tag/src                  registered result, echoed tag, serviced port
//   busy                              high whenever an op is in flight
module alu_req_scheduler #(
  parameter int W    = 64,
  parameter int CMDW = 5,
  parameter int OPMW = 7,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [CMDW-1:0] req0_cmd,
  input  logic [OPMW-1:0] req0_opm,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [CMDW-1:0] req1_cmd,
  input  logic [OPMW-1:0] req1_opm,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [TAGW-1:0] req1_tag,
  output logic [CMDW-1:0] alu_cmd,
  output logic [OPMW-1:0] alu_opm,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_src,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;       // port that wins when both are valid
  logic [CMDW-1:0] alu_cmd_q, alu_cmd_d;
  logic [OPMW-1:0] alu_opm_q, alu_opm_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [TAGW-1:0] tag_lat_q, tag_lat_d;
  logic            src_lat_q, src_lat_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic            rsp_src_q, rsp_src_d;
  logic            grant_src;
  logic            grant_vld;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    alu_cmd_d  = alu_cmd_q;
    alu_opm_d  = alu_opm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    tag_lat_d  = tag_lat_q;
    src_lat_d  = src_lat_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_src_d  = rsp_src_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    grant_src  = (req0_valid && req1_valid) ? prio_q : req1_valid;
    grant_vld  = req0_valid || req1_valid;

    unique case (state_q)
      IDLE: begin
        // Ready is gated by rst_n so both readies read 0 while reset is held.
        if (grant_vld && rst_n) begin
          req0_ready = !grant_src;
          req1_ready = grant_src;
          // ALU inputs are loaded here and nowhere else: the ALU keeps flag
          // state, so re-driving or parking its inputs would corrupt N/Z.
          alu_cmd_d  = grant_src ? req1_cmd : req0_cmd;
          alu_opm_d  = grant_src ? req1_opm : req0_opm;
          alu_a_d    = grant_src ? req1_a   : req0_a;
          alu_b_d    = grant_src ? req1_b   : req0_b;
          tag_lat_d  = grant_src ? req1_tag : req0_tag;
          src_lat_d  = grant_src;
          prio_d     = !grant_src;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d = alu_out;
        rsp_tag_d  = tag_lat_q;
        rsp_src_d  = src_lat_q;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      alu_cmd_q  <= '0;
      alu_opm_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      tag_lat_q  <= '0;
      src_lat_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      alu_cmd_q  <= alu_cmd_d;
      alu_opm_q  <= alu_opm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      tag_lat_q  <= tag_lat_d;
      src_lat_q  <= src_lat_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_src_q  <= rsp_src_d;
    end
  end

  assign alu_cmd  = alu_cmd_q;
  assign alu_opm  = alu_opm_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign rsp_data = rsp_data_q;
  assign rsp_tag  = rsp_tag_q;
  assign rsp_src  = rsp_src_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - self-checking bench for alu_req_scheduler
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_cmd, req1_cmd, alu_cmd;
  logic [6:0]  req0_opm, req1_opm, alu_opm;
  logic [63:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]  req0_tag, req1_tag, rsp_tag;
  logic        rsp_valid, rsp_ready, rsp_src, busy;

  int vectors = 0;
  int miscompares = 0;
  logic model_pref;        // port the bench expects to win a two-way contention
  logic [63:0] flag_q = '0; // flag word held inside the stand-in ALU

  always #5 clk = ~clk;

  alu_req_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_opm(req0_opm),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_opm(req1_opm),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_cmd(alu_cmd), .alu_opm(alu_opm), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_src(rsp_src), .busy(busy)
  );

  // Behaviour of the shared ALU: 0 ZERO, 1 ADD, 2 PASSFLAG, 3 LOADFLAG, 4 NOT, 5 XOR, 6 SUB.
  function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [6:0] o,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] f);
    case (c)
      5'd0:    alu_fn = 64'd0;
      5'd1:    alu_fn = a + b;
      5'd2:    alu_fn = f;
      5'd3:    alu_fn = a;
      5'd4:    alu_fn = ~a;
      5'd5:    alu_fn = a ^ b;
      5'd6:    alu_fn = a - b;
      default: alu_fn = b ^ {52'd0, o, c};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_cmd, alu_opm, alu_a, alu_b, flag_q);

  // Flags follow whatever sits on the ALU inputs every cycle; only PASSFLAG leaves them alone.
  always @(posedge clk) begin
    case (alu_cmd)
      5'd3:    flag_q <= alu_a;
      5'd2:    flag_q <= flag_q;
      default: flag_q <= {62'd0, alu_out[63], alu_out == 64'd0};
    endcase
  end

  function automatic logic [4:0] rand_cmd();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: rand_cmd = 5'd0;
      1: rand_cmd = 5'd1;
      2: rand_cmd = 5'd4;
      3: rand_cmd = 5'd5;
      4: rand_cmd = 5'd6;
      default: rand_cmd = 5'($urandom_range(7, 31));
    endcase
  endfunction

  task automatic set_port(input int p, input logic v, input logic [4:0] c, input logic [6:0] o,
                          input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    if (p == 0) begin
      req0_valid = v; req0_cmd = c; req0_opm = o; req0_a = a; req0_b = b; req0_tag = t;
    end else begin
      req1_valid = v; req1_cmd = c; req1_opm = o; req1_a = a; req1_b = b; req1_tag = t;
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_port(0, 1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 4'd0);
    set_port(1, 1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 4'd0);
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy, rsp_valid, req0_ready, req1_ready});
    end
    vectors++;
    if ({rsp_data, rsp_tag, rsp_src} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_rsp got %h/%h/%b exp 0", rsp_data, rsp_tag, rsp_src);
    end
    vectors++;
    if ({alu_cmd, alu_opm, alu_a, alu_b} !== 140'd0) begin
      miscompares++;
      $display("FAIL reset_alu got %h/%h/%h/%h exp 0", alu_cmd, alu_opm, alu_a, alu_b);
    end
    rst_n = 1'b1;
    model_pref = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_port(0, 1'b1, 5'b00100, 7'd0, 64'd0, 64'($urandom), 4'd3);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_ready got %b exp 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    model_pref = 1'b1;
    vectors++;
    if ({busy, rsp_valid, alu_cmd} !== {2'b10, 5'b00100}) begin
      miscompares++;
      $display("FAIL basic_issue got %b/%b/%h exp 1/0/04", busy, rsp_valid, alu_cmd);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_rsp got %b/%h/%h/%b exp 1/ffffffffffffffff/3/0",
               rsp_valid, rsp_data, rsp_tag, rsp_src);
    end
    accept_rsp();
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_done got %b exp 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_random();
    logic [4:0]  c[2];
    logic [6:0]  o[2];
    logic [63:0] a[2], b[2];
    logic [3:0]  t[2];
    logic        v[2];
    logic        ep, early;
    logic [63:0] exp_data;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        v[p] = 1'($urandom_range(0, 1));
        c[p] = rand_cmd(); o[p] = 7'($urandom); t[p] = 4'($urandom);
        a[p] = {$urandom, $urandom}; b[p] = {$urandom, $urandom};
      end
      if (!v[0] && !v[1]) v[0] = 1'b1;
      set_port(0, v[0], c[0], o[0], a[0], b[0], t[0]);
      set_port(1, v[1], c[1], o[1], a[1], b[1], t[1]);
      #1;
      ep = (v[0] && v[1]) ? model_pref : v[1];
      exp_data = alu_fn(c[ep], o[ep], a[ep], b[ep], 64'd0);
      vectors++;
      if ({req0_ready, req1_ready} !== {!ep, ep}) begin
        miscompares++;
        $display("FAIL rand_grant[%0d] got %b exp %b", i, {req0_ready, req1_ready}, {!ep, ep});
      end
      early = 1'($urandom_range(0, 1));
      rsp_ready = early;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      model_pref = !ep;
      vectors++;
      if ({busy, rsp_valid, alu_cmd, alu_a} !== {2'b10, c[ep], a[ep]}) begin
        miscompares++;
        $display("FAIL rand_issue[%0d] got %b/%b/%h/%h exp 1/0/%h/%h",
                 i, busy, rsp_valid, alu_cmd, alu_a, c[ep], a[ep]);
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, exp_data, t[ep], ep}) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d] got %b/%h/%h/%b exp 1/%h/%h/%b",
                 i, rsp_valid, rsp_data, rsp_tag, rsp_src, exp_data, t[ep], ep);
      end
      if (!early) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      accept_rsp();
      vectors++;
      if ({rsp_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL rand_done[%0d] got %b exp 00", i, {rsp_valid, busy});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ep;
    logic [63:0] a0, a1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
      set_port(0, 1'b1, 5'd4, 7'd0, a0, 64'd0, 4'(i));
      set_port(1, 1'b1, 5'd4, 7'd0, a1, 64'd0, 4'(i + 8));
      #1;
      ep = model_pref;
      vectors++;
      if ({req0_ready, req1_ready} !== {!ep, ep}) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d] got %b exp %b", i, {req0_ready, req1_ready}, {!ep, ep});
      end
      model_pref = !ep;
      repeat (2) @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_src, rsp_data} !== {1'b1, ep, ep ? ~a1 : ~a0}) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d] got %b/%b/%h exp 1/%b/%h",
                 i, rsp_valid, rsp_src, rsp_data, ep, ep ? ~a1 : ~a0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    set_port(1, 1'b1, 5'd1, 7'd0, a, b, 4'hA);
    set_port(0, 1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 4'd0);
    repeat (2) @(negedge clk);
    model_pref = 1'b0;
    req0_valid = 1'b1;          // both held valid while the response stalls
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_src, req0_ready, req1_ready} !==
          {1'b1, a + b, 4'hA, 1'b1, 2'b00}) begin
        miscompares++;
        $display("FAIL stall[%0d] got %b/%h/%h/%b/%b%b exp 1/%h/a/1/00",
                 i, rsp_valid, rsp_data, rsp_tag, rsp_src, req0_ready, req1_ready, a + b);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    accept_rsp();
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_done got %b exp 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_flag_hold();
    set_port(0, 1'b1, 5'd3, 7'd0, 64'h1234, 64'd0, 4'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    model_pref = 1'b1;
    @(negedge clk);
    accept_rsp();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({alu_cmd, alu_a} !== {5'd3, 64'h1234}) begin
        miscompares++;
        $display("FAIL flag_idle[%0d] got %h/%h exp 03/1234", i, alu_cmd, alu_a);
      end
      @(negedge clk);
    end
    set_port(0, 1'b1, 5'b00010, 7'd0, 64'd0, 64'd0, 4'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data} !== {1'b1, 64'h1234}) begin
      miscompares++;
      $display("FAIL flag_pass got %b/%h exp 1/1234", rsp_valid, rsp_data);
    end
    accept_rsp();
  endtask

  task automatic test_reset_inflight();
    set_port(1, 1'b1, 5'd5, 7'd9, 64'hFF, 64'h0F, 4'd7);
    @(negedge clk);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, rsp_valid, rsp_data, rsp_tag, rsp_src, alu_cmd, alu_opm, alu_a, alu_b} !== 211'd0) begin
      miscompares++;
      $display("FAIL rst_flight got %b/%b/%h/%h/%b/%h/%h/%h/%h exp 0", busy, rsp_valid,
               rsp_data, rsp_tag, rsp_src, alu_cmd, alu_opm, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_pref = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_dropped[%0d] got %b exp 00", i, {rsp_valid, busy});
      end
    end
    rsp_ready = 1'b0;
    set_port(0, 1'b1, 5'd1, 7'd0, 64'd5, 64'd6, 4'd4);
    set_port(1, 1'b1, 5'd1, 7'd0, 64'd7, 64'd8, 4'd5);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_next_grant got %b exp 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_pref = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, 64'd11, 4'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_next_rsp got %b/%h/%h/%b exp 1/b/4/0", rsp_valid, rsp_data, rsp_tag, rsp_src);
    end
    accept_rsp();
  endtask

  task automatic test_drop();
    // Occupy the scheduler so req0 can come and go without being granted.
    set_port(0, 1'b1, 5'd0, 7'd0, 64'd0, 64'd0, 4'd0);
    @(negedge clk);
    set_port(1, 1'b1, 5'd6, 7'd0, 64'd100, 64'd1, 4'd9);
    model_pref = 1'b1;
    vectors++;
    if (req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_busy got %b exp 0", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    accept_rsp();
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL drop_grant got %b exp 01", {req0_ready, req1_ready});
    end
    model_pref = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_src} !== {1'b1, 64'd99, 4'd9, 1'b1}) begin
      miscompares++;
      $display("FAIL drop_rsp got %b/%h/%h/%b exp 1/63/9/1", rsp_valid, rsp_data, rsp_tag, rsp_src);
    end
    accept_rsp();
    set_port(0, 1'b1, 5'd4, 7'd0, 64'd0, 64'd0, 4'd1);
    set_port(1, 1'b1, 5'd4, 7'd0, 64'd0, 64'd0, 4'd2);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== {!model_pref, model_pref}) begin
      miscompares++;
      $display("FAIL drop_ptr got %b exp %b", {req0_ready, req1_ready}, {!model_pref, model_pref});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    accept_rsp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_stall();
    test_flag_hold();
    test_reset_inflight();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
